rom_sequencer: RTL and testbench
================================

# rom_sequencer

Tick-driven ROM playback sequencer: the consumer at the far end of the one-cycle `Enable` strobe produced by the system timer. It walks an address range in a synchronous ROM, advancing one step for every `DIVIDE` strobes, and presents each fetched word with a one-cycle valid pulse. It supports one-shot, loop and ping-pong playback, and sits between the timer and the display/output datapath.

## Interface
- `ADDR_WIDTH`, default 5: ROM address width.
- `DATA_WIDTH`, default 8: ROM word width.
- `DIVIDE`, default 1: number of `Enable` strobes per address step. Legal range 1..255.

- `Clk` input 1: system clock; all logic is on the rising edge.
- `Reset` input 1: synchronous, active-low reset.
- `Enable` input 1: timer strobe. Each cycle it is sampled high counts as one tick.
- `Start` input 1: begins playback when sampled in IDLE.
- `Stop` input 1: aborts playback.
- `Mode` input 2: 00 one-shot, 01 loop, 10 ping-pong, 11 treated as one-shot. Latched on Start.
- `FirstAddr` input ADDR_WIDTH: range start. Latched on Start.
- `LastAddr` input ADDR_WIDTH: range end. Latched on Start.
- `RomData` input DATA_WIDTH: ROM read data, one-cycle latency from `Address`.
- `Address` output ADDR_WIDTH: registered ROM address.
- `DataOut` output DATA_WIDTH: last captured ROM word.
- `DataValid` output 1: high for one cycle when `DataOut` updates.
- `Busy` output 1: high whenever state is not IDLE.
- `Done` output 1: one-cycle pulse when a one-shot sequence completes.

## Operation
- Reset (`Reset`=0 at an edge) puts the block in IDLE. Reset values: `Address`=0, `DataOut`=0, `DataValid`=0, `Busy`=0, `Done`=0, direction up, tick count 0. Reset overrides all other inputs, including mid-sequence.
- States and transitions:
  - IDLE: `Start`=1 and `FirstAddr`<=`LastAddr` → latch Mode/First/Last, set `Address`<=First, direction up, go to READ. `Start` with First>Last is ignored; the block stays in IDLE with no outputs changed.
  - READ: one cycle while the ROM samples `Address`; always goes to LOAD.
  - LOAD: at the exiting edge, `DataOut`<=`RomData` and `DataValid`<=1; clear tick count; go to WAIT.
  - WAIT: count `Enable` cycles. On the DIVIDE-th tick, step as below.
- Step rules:
  - Direction up and `Address`≠Last: `Address`+1, go to READ.
  - Direction down and `Address`≠First: `Address`−1, go to READ.
  - End of range, one-shot: go to IDLE, `Done`<=1, `Address` holds Last.
  - End of range, loop: `Address`<=First, go to READ.
  - End of range, ping-pong: reverse direction and step one toward the other end. If First==Last, hold the address, re-read, and go to READ.
- Ticks arriving in READ or LOAD are discarded. The tick count is only active in WAIT.
- `Stop`=1 in any non-IDLE state → IDLE at that edge. `Address` and `DataOut` hold; no `Done`; `DataValid`=0. `Stop` has priority over a coincident tick.
- `Start` while `Busy` is ignored. `Stop` in IDLE has no effect.
- Address arithmetic is ADDR_WIDTH wide. Wrap cannot occur because stepping is bounded by First/Last.

## Timing
- `Start` sampled at edge k: `Address`=First and `Busy`=1 after edge k. The first `DataValid` is high in the cycle after edge k+2.
- Completing tick sampled at edge t: the new `Address` is valid after edge t, and its `DataValid` is high in the cycle after edge t+2.
- Minimum step period is 3 cycles (READ, LOAD, WAIT); faster ticks are dropped.
- `Done` is high in the single cycle after the completing edge, with `Busy`=0 in that same cycle. `DataValid` and `Done` never coincide.

## Test plan
- Reset: hold `Reset`=0 two cycles with `Start`=1 → all outputs 0, `Busy`=0. Release, pulse `Start` with First=2, Last=4, Mode=00 → `Address`=2 next cycle, `DataValid` two cycles later with `DataOut`=ROM[2].
- One-shot, DIVIDE=1, First=2, Last=4, tick every 8 cycles → `DataValid` words ROM[2], ROM[3], ROM[4]; a single `Done` pulse after the third tick; `Address`=4 and `Busy`=0 afterwards.
- Loop with First=30, Last=31 (ADDR_WIDTH=5) → address sequence 30, 31, 30, 31, …; never `Done`. Ping-pong with First=0, Last=2 → 0, 1, 2, 1, 0, 1. Ping-pong with First=Last=5 → repeated `DataValid` for ROM[5].
- DIVIDE=4 → the step occurs only on the 4th tick in WAIT. Ticks injected during READ/LOAD are not counted; back-to-back ticks every cycle give a 3-cycle step period.
- `Stop` coincident with the completing tick in WAIT → IDLE, `Address` unchanged, no `DataValid`, no `Done`.
- `Start` with First=6, Last=3 → ignored, `Busy` stays 0. `Start` pulsed while `Busy`=1 → no restart.
- `Reset`=0 mid-sequence → IDLE next edge with reset values.

Source files
------------

// File: rtl/rom_sequencer_if.sv
// Bus between the ROM playback sequencer and its surroundings: timer strobe,
// playback control, ROM read port and the presented output word.
interface rom_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);
  logic                  Enable;
  logic                  Start;
  logic                  Stop;
  logic [1:0]            Mode;
  logic [ADDR_WIDTH-1:0] FirstAddr;
  logic [ADDR_WIDTH-1:0] LastAddr;
  logic [DATA_WIDTH-1:0] RomData;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataValid;
  logic                  Busy;
  logic                  Done;

  // Controller / ROM side: drives control and read data, observes outputs.
  modport master (
    output Enable, Start, Stop, Mode, FirstAddr, LastAddr, RomData,
    input  Address, DataOut, DataValid, Busy, Done
  );

  // Sequencer side.
  modport slave (
    input  Enable, Start, Stop, Mode, FirstAddr, LastAddr, RomData,
    output Address, DataOut, DataValid, Busy, Done
  );
endinterface

// File: rtl/rom_sequencer.sv
// Tick-driven ROM playback sequencer. Walks [First, Last] of a synchronous ROM,
// one step per DIVIDE timer strobes, in one-shot, loop or ping-pong order.
// DIVIDE must lie in 1..255 (tick counter is 8 bits).
module rom_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DIVIDE     = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  rom_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_LOAD, S_WAIT} state_t;

  localparam logic [1:0]            MODE_LOOP = 2'b01;
  localparam logic [1:0]            MODE_PING = 2'b10;
  localparam logic [7:0]            TICK_LAST = 8'(DIVIDE - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] first_q, first_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            mode_q, mode_d;
  logic [7:0]            tick_q, tick_d;
  logic                  dir_q, dir_d;      // 0 = up, 1 = down
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  at_end;

  // State and datapath registers; synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      first_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      tick_q  <= '0;
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      last_q  <= last_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Next state plus address/tick/data updates; pulses default low.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    last_d  = last_q;
    data_d  = data_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    dir_d   = dir_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    // End of range in the current direction of travel.
    at_end  = dir_q ? (addr_q == first_q) : (addr_q == last_q);
    case (state_q)
      S_IDLE: begin
        // Reversed range is silently rejected.
        if (bus.Start && (bus.FirstAddr <= bus.LastAddr)) begin
          mode_d  = bus.Mode;
          first_d = bus.FirstAddr;
          last_d  = bus.LastAddr;
          addr_d  = bus.FirstAddr;
          dir_d   = 1'b0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = bus.Stop ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        if (bus.Stop) begin
          state_d = S_IDLE;
        end else begin
          data_d  = bus.RomData;
          valid_d = 1'b1;
          tick_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Stop wins over a coincident completing tick.
        if (bus.Stop) begin
          state_d = S_IDLE;
        end else if (bus.Enable) begin
          if (tick_q != TICK_LAST) begin
            tick_d = tick_q + 8'd1;
          end else begin
            tick_d  = '0;
            state_d = S_READ;
            if (!at_end) begin
              addr_d = dir_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
            end else begin
              case (mode_q)
                MODE_LOOP: begin
                  addr_d = first_q;
                  dir_d  = 1'b0;
                end
                MODE_PING: begin
                  // Single-entry range just re-reads the same word.
                  if (first_q != last_q) begin
                    dir_d  = ~dir_q;
                    addr_d = dir_q ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
                  end
                end
                default: begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                end
              endcase
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are straight from registers.
  always_comb begin
    bus.Address   = addr_q;
    bus.DataOut   = data_q;
    bus.DataValid = valid_q;
    bus.Done      = done_q;
    bus.Busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_rom_sequencer.sv
// Directed bench for rom_sequencer. ROM word at address a is 8'hA0 + a.
module tb_rom_sequencer;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  rom_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) s1 ();
  rom_sequencer_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) s4 ();

  rom_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DIVIDE(1)) u1 (.Clk(Clk), .Reset(Reset), .bus(s1.slave));
  rom_sequencer #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DIVIDE(4)) u4 (.Clk(Clk), .Reset(Reset), .bus(s4.slave));

  // Synchronous ROMs, one-cycle latency.
  always @(posedge Clk) begin
    s1.RomData <= 8'hA0 + 8'(s1.Address);
    s4.RomData <= 8'hA0 + 8'(s4.Address);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  logic [4:0] aq[$];
  logic [7:0] dq[$];
  int         cq[$];

  always @(posedge Clk) cyc++;

  // Log every presented word of u1 and count Done pulses.
  always @(negedge Clk) begin
    if (s1.DataValid) begin
      aq.push_back(s1.Address);
      dq.push_back(s1.DataOut);
      cq.push_back(cyc);
    end
    if (s1.Done) done_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic start1(input logic [1:0] m, input logic [4:0] f, input logic [4:0] l);
    s1.Start = 1'b1; s1.Mode = m; s1.FirstAddr = f; s1.LastAddr = l;
    @(negedge Clk);
    s1.Start = 1'b0;
  endtask

  task automatic tick1();
    s1.Enable = 1'b1;
    @(negedge Clk);
    s1.Enable = 1'b0;
  endtask

  task automatic stop1();
    s1.Stop = 1'b1;
    @(negedge Clk);
    s1.Stop = 1'b0;
  endtask

  task automatic tick4();
    s4.Enable = 1'b1;
    @(negedge Clk);
    s4.Enable = 1'b0;
  endtask

  task automatic clrq();
    aq.delete(); dq.delete(); cq.delete(); done_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    s1.Enable = 0; s1.Start = 0; s1.Stop = 0; s1.Mode = 0; s1.FirstAddr = 0; s1.LastAddr = 0;
    s4.Enable = 0; s4.Start = 0; s4.Stop = 0; s4.Mode = 0; s4.FirstAddr = 0; s4.LastAddr = 0;
    @(negedge Clk);
    // Reset held two cycles with Start asserted.
    s1.Start = 1; s1.FirstAddr = 2; s1.LastAddr = 4;
    cycles(2);
    chk("rst_addr", s1.Address, 0);
    chk("rst_data", s1.DataOut, 0);
    chk("rst_valid", s1.DataValid, 0);
    chk("rst_busy", s1.Busy, 0);
    chk("rst_done", s1.Done, 0);
    chk("rst_addr4", s4.Address, 0);
    s1.Start = 0;
    Reset = 1;
    clrq();

    // One-shot 2..4, tick every 8 cycles.
    start1(2'b00, 5'd2, 5'd4);
    chk("os_addr0", s1.Address, 2);
    chk("os_busy0", s1.Busy, 1);
    cycles(1);
    chk("os_valid_early", s1.DataValid, 0);
    cycles(1);
    chk("os_valid0", s1.DataValid, 1);
    chk("os_data0", s1.DataOut, 8'hA2);
    for (int i = 0; i < 3; i++) begin
      cycles(7);
      tick1();
    end
    chk("os_done", s1.Done, 1);
    chk("os_done_busy", s1.Busy, 0);
    cycles(2);
    chk("os_n", aq.size(), 3);
    chk("os_w0", dq[0], 8'hA2);
    chk("os_w1", dq[1], 8'hA3);
    chk("os_w2", dq[2], 8'hA4);
    chk("os_done_n", done_n, 1);
    chk("os_addr_end", s1.Address, 4);
    chk("os_busy_end", s1.Busy, 0);

    // Loop 30..31.
    clrq();
    start1(2'b01, 5'd30, 5'd31);
    cycles(4);
    repeat (4) begin tick1(); cycles(4); end
    stop1();
    chk("lp_n", aq.size(), 5);
    chk("lp_a0", aq[0], 30);
    chk("lp_a1", aq[1], 31);
    chk("lp_a2", aq[2], 30);
    chk("lp_a3", aq[3], 31);
    chk("lp_a4", aq[4], 30);
    chk("lp_d1", dq[1], 8'hBF);
    chk("lp_done_n", done_n, 0);
    chk("lp_stop_busy", s1.Busy, 0);
    chk("lp_stop_addr", s1.Address, 30);

    // Ping-pong 0..2.
    clrq();
    start1(2'b10, 5'd0, 5'd2);
    cycles(4);
    repeat (5) begin tick1(); cycles(4); end
    stop1();
    chk("pp_n", aq.size(), 6);
    chk("pp_a1", aq[1], 1);
    chk("pp_a2", aq[2], 2);
    chk("pp_a3", aq[3], 1);
    chk("pp_a4", aq[4], 0);
    chk("pp_a5", aq[5], 1);
    chk("pp_done_n", done_n, 0);

    // Ping-pong single entry 5..5.
    clrq();
    start1(2'b10, 5'd5, 5'd5);
    cycles(4);
    repeat (3) begin tick1(); cycles(4); end
    stop1();
    chk("pp1_n", aq.size(), 4);
    chk("pp1_a3", aq[3], 5);
    chk("pp1_d3", dq[3], 8'hA5);
    chk("pp1_done_n", done_n, 0);

    // Ticks every cycle: step period of 3.
    clrq();
    s1.Enable = 1;
    start1(2'b01, 5'd10, 5'd12);
    cycles(12);
    s1.Enable = 0;
    stop1();
    chk("b2b_n", aq.size(), 4);
    chk("b2b_a1", aq[1], 11);
    chk("b2b_a2", aq[2], 12);
    chk("b2b_a3", aq[3], 10);
    chk("b2b_d0", dq[0], 8'hAA);
    chk("b2b_gap1", cq[1] - cq[0], 3);
    chk("b2b_gap3", cq[3] - cq[2], 3);
    chk("b2b_stop_addr", s1.Address, 11);

    // Stop coincident with completing tick.
    clrq();
    start1(2'b00, 5'd2, 5'd4);
    cycles(5);
    s1.Stop = 1; s1.Enable = 1;
    @(negedge Clk);
    s1.Stop = 0; s1.Enable = 0;
    chk("stp_busy", s1.Busy, 0);
    chk("stp_addr", s1.Address, 2);
    chk("stp_done", s1.Done, 0);
    chk("stp_valid", s1.DataValid, 0);
    cycles(4);
    chk("stp_n", aq.size(), 1);
    chk("stp_done_n", done_n, 0);

    // Reversed range ignored.
    start1(2'b00, 5'd6, 5'd3);
    chk("rev_busy", s1.Busy, 0);
    chk("rev_addr", s1.Address, 2);
    cycles(3);
    chk("rev_n", aq.size(), 1);

    // Start while busy ignored, then reset mid-sequence.
    clrq();
    start1(2'b00, 5'd2, 5'd4);
    cycles(4);
    start1(2'b01, 5'd8, 5'd9);
    chk("sb_addr", s1.Address, 2);
    chk("sb_busy", s1.Busy, 1);
    cycles(2);
    tick1();
    chk("sb_step", s1.Address, 3);
    cycles(1);
    Reset = 0;
    @(negedge Clk);
    chk("mr_addr", s1.Address, 0);
    chk("mr_data", s1.DataOut, 0);
    chk("mr_valid", s1.DataValid, 0);
    chk("mr_busy", s1.Busy, 0);
    chk("mr_done", s1.Done, 0);
    Reset = 1;
    cycles(3);
    chk("mr_n", aq.size(), 1);

    // DIVIDE=4; ticks held through IDLE/READ/LOAD are not counted.
    s4.Start = 1; s4.Mode = 2'b00; s4.FirstAddr = 1; s4.LastAddr = 3; s4.Enable = 1;
    @(negedge Clk);
    s4.Start = 0;
    chk("d4_addr0", s4.Address, 1);
    cycles(2);
    s4.Enable = 0;
    chk("d4_valid0", s4.DataValid, 1);
    chk("d4_data0", s4.DataOut, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      tick4();
      cycles(1);
      chk("d4_hold", s4.Address, 1);
    end
    tick4();
    chk("d4_step", s4.Address, 2);
    chk("d4_busy", s4.Busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
